// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data memory.
// Sub-word stores use read-modify-write; faults never reach the memory.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr,
    output logic        Mem_CS,
    output logic        Mem_RW,
    output logic [3:0]  Mem_BE,
    output logic [29:0] Mem_Addr,
    output logic [31:0] Mem_DataIn,
    input  logic [31:0] Mem_DataOut,
    input  logic        Mem_DataReady
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        req_misalign;
    logic        req_oor;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  a,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        unique case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'b00:   load_ext = u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = u ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [31:0] d,
        input logic [1:0]  sz,
        input logic [1:0]  a
    );
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            unique case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (a[1]) begin
            r[31:16] = d[15:0];
        end else begin
            r[15:0] = d[15:0];
        end
        merge = r;
    endfunction

    assign req_misalign = (req_size == 2'b11)
                        | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                        | ((req_size == 2'b01) & req_addr[0]);
    assign req_oor = req_addr[31:2] >= 30'(MEM_WORDS);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merged_d     = merged_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        fault_addr_d = fault_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_misalign) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b00;
                        fault_addr_d = req_addr;
                    end else if (req_oor) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                        fault_addr_d = req_addr;
                    end else if (req_we && req_size == 2'b10) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD, S_WR: begin
                if (Mem_DataReady) begin
                    cnt_d = '0;
                    if (state_q == S_RD) begin
                        state_d = S_CAP;
                    end else begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                // TIMEOUT-th consecutive stalled cycle aborts the access
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b10;
                    fault_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAP: begin
                cnt_d = '0;
                if (we_q) begin
                    merged_d = merge(Mem_DataOut, wdata_q, size_q, addr_q[1:0]);
                    state_d  = S_WR;
                end else begin
                    rsp_rdata_d = load_ext(Mem_DataOut, size_q, addr_q[1:0], uns_q);
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_addr = fault_addr_q;
    assign Mem_CS     = (state_q == S_RD) || (state_q == S_WR);
    assign Mem_RW     = (state_q == S_WR);
    assign Mem_BE     = 4'b1111;
    assign Mem_Addr   = addr_q[31:2];
    assign Mem_DataIn = (size_q == 2'b10) ? wdata_q : merged_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed loads, stores, faults,
// timeouts, back-to-back traffic and reset during a write.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;
    logic        Mem_CS;
    logic        Mem_RW;
    logic [3:0]  Mem_BE;
    logic [29:0] Mem_Addr;
    logic [31:0] Mem_DataIn;
    logic [31:0] Mem_DataOut = '0;
    logic        Mem_DataReady = 1'b1;

    mem_access_ctrl #(.MEM_WORDS(32), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .fault(fault), .fault_code(fault_code),
        .fault_addr(fault_addr),
        .Mem_CS(Mem_CS), .Mem_RW(Mem_RW), .Mem_BE(Mem_BE),
        .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
        .Mem_DataOut(Mem_DataOut), .Mem_DataReady(Mem_DataReady)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [31:0] mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge Clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (Mem_CS && Mem_DataReady) begin
            if (Mem_RW) mem[Mem_Addr[4:0]] <= Mem_DataIn;
            else Mem_DataOut <= mem[Mem_Addr[4:0]];
        end
    end

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        logic [31:0] val;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    typedef struct {
        bit          rw;
        logic [29:0] addr;
        logic [31:0] data;
        string       name;
    } mexp_t;

    exp_t  rq[$];
    mexp_t mq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_rsp();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && (rsp_valid || fault)) begin
                chk("rsp_fault_exclusive", 32'(rsp_valid && fault), 32'd0);
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk({e.name, "_kind"}, 32'(fault), 32'(e.is_fault));
                    if (e.is_fault) begin
                        chk({e.name, "_code"}, 32'(fault_code), 32'(e.code));
                        chk({e.name, "_faddr"}, fault_addr, e.val);
                    end else begin
                        chk({e.name, "_rdata"}, rsp_rdata, e.val);
                    end
                    chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    endtask

    task automatic mon_mem();
        mexp_t m;
        forever begin
            @(negedge Clk);
            if (!Reset && Mem_CS && Mem_DataReady) begin
                chk("mem_be", 32'(Mem_BE), 32'hF);
                if (mq.size() == 0) begin
                    chk("unexpected_mem", 32'd1, 32'd0);
                end else begin
                    m = mq.pop_front();
                    chk({m.name, "_mrw"}, 32'(Mem_RW), 32'(m.rw));
                    chk({m.name, "_maddr"}, 32'(Mem_Addr), 32'(m.addr));
                    if (m.rw) chk({m.name, "_mdata"}, Mem_DataIn, m.data);
                end
            end
        end
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int acc);
        int n;
        @(negedge Clk);
        req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge Clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clk);
        while (busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic preload(input logic [4:0] w, input logic [31:0] d);
        wait_idle();
        pre_addr = w; pre_data = d; pre_we = 1'b1;
        @(posedge Clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input bit u, input logic [31:0] a,
                      input logic [31:0] exp, input string name, output int acc);
        issue(1'b0, sz, u, a, 32'd0, acc);
        mq.push_back('{1'b0, a[31:2], 32'd0, name});
        rq.push_back('{1'b0, 2'b00, exp, 2, acc, name});
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] wexp,
                      input string name, output int acc);
        issue(1'b1, sz, 1'b0, a, wd, acc);
        if (sz != 2'b10) mq.push_back('{1'b0, a[31:2], 32'd0, name});
        mq.push_back('{1'b1, a[31:2], wexp, name});
        rq.push_back('{1'b0, 2'b00, 32'd0, (sz == 2'b10) ? 1 : 3, acc, name});
    endtask

    task automatic flt(input bit we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [1:0] code, input int lat, input string name);
        int acc;
        issue(we, sz, 1'b0, a, 32'h0, acc);
        rq.push_back('{1'b1, code, a, lat, acc, name});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, n, cs;
        fork
            mon_rsp();
            mon_mem();
        join_none

        repeat (3) @(negedge Clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cs", 32'(Mem_CS), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_fcode", 32'(fault_code), 32'd0);
        chk("rst_faddr", fault_addr, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        preload(5'd2, 32'h8000_00F3);
        ld(2'b10, 1'b0, 32'h8, 32'h8000_00F3, "lw_8", a0);
        preload(5'd2, 32'h0000_F300);
        ld(2'b00, 1'b0, 32'h9, 32'hFFFF_FFF3, "lb_9", a0);
        ld(2'b00, 1'b1, 32'h9, 32'h0000_00F3, "lbu_9", a0);
        preload(5'd2, 32'hBEEF_1234);
        ld(2'b01, 1'b1, 32'hA, 32'h0000_BEEF, "lhu_A", a0);
        ld(2'b01, 1'b0, 32'hA, 32'hFFFF_BEEF, "lh_A", a0);
        ld(2'b01, 1'b0, 32'h8, 32'h0000_1234, "lh_8", a0);
        ld(2'b00, 1'b0, 32'hB, 32'hFFFF_FFBE, "lb_B", a0);

        preload(5'd1, 32'h1122_3344);
        st(2'b00, 32'h5, 32'h0000_00AA, 32'h1122_AA44, "sb_5", a0);
        ld(2'b10, 1'b0, 32'h4, 32'h1122_AA44, "lw_4_sb", a0);
        preload(5'd1, 32'h1122_3344);
        st(2'b01, 32'h6, 32'h0000_5566, 32'h5566_3344, "sh_6", a0);
        ld(2'b10, 1'b0, 32'h4, 32'h5566_3344, "lw_4_sh", a0);

        wait_idle();
        flt(1'b0, 2'b10, 32'h2, 2'b00, 0, "lw_2_mis");
        flt(1'b1, 2'b01, 32'h1, 2'b00, 0, "sh_1_mis");
        flt(1'b0, 2'b11, 32'h0, 2'b00, 0, "size_ill");
        flt(1'b0, 2'b10, 32'h80, 2'b01, 0, "lw_80_oor");
        flt(1'b1, 2'b00, 32'h81, 2'b01, 0, "sb_81_oor");
        flt(1'b0, 2'b10, 32'h82, 2'b00, 0, "lw_82_prio");
        st(2'b10, 32'h7C, 32'h1234_5678, 32'h1234_5678, "sw_7C", a0);
        ld(2'b10, 1'b0, 32'h7C, 32'h1234_5678, "lw_7C", a0);

        wait_idle();
        Mem_DataReady = 1'b0;
        flt(1'b0, 2'b10, 32'h0, 2'b10, 15, "lw_tmo");
        cs = 0;
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            if (Mem_CS) cs++;
            if (!busy) break;
            n++;
        end
        chk("rd_tmo_cs_cycles", 32'(cs), 32'd15);
        flt(1'b1, 2'b10, 32'h10, 2'b10, 15, "sw_tmo");
        wait_idle();
        Mem_DataReady = 1'b1;

        st(2'b10, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, "sw_b2b", a0);
        ld(2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, "lw_b2b", a1);
        chk("b2b_gap", 32'(a1 - a0), 32'd2);

        preload(5'd1, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AA, a0);
        mq.push_back('{1'b0, 30'd1, 32'd0, "sb_rst"});
        n = 0;
        while (n < 20) begin
            @(posedge Clk);
            #1;
            if (Mem_CS && Mem_RW) break;
            n++;
        end
        chk("rst_in_wr_reached", 32'(Mem_CS && Mem_RW), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_wr_cs", 32'(Mem_CS), 32'd0);
        chk("rst_wr_busy", 32'(busy), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_wr_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_wr_fault", 32'(fault), 32'd0);
        chk("rst_wr_fcode", 32'(fault_code), 32'd0);
        chk("rst_wr_faddr", fault_addr, 32'd0);
        chk("rst_wr_rdata", rsp_rdata, 32'd0);
        ld(2'b10, 1'b0, 32'h4, 32'h1122_3344, "lw_after_rst", a0);

        wait_idle();
        repeat (3) @(negedge Clk);
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("mem_queue_empty", 32'(mq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
